// File: rtl/muller_c_hs_seq.sv
// muller_c_hs_seq: sequences 4-phase handshakes through an external Muller C-element.
// Optional b_out skew with early-fire detection: define MULLER_C_HS_SEQ_SKEW_EN.
module muller_c_hs_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       clr,
    input  logic [7:0] n_cycles,
    input  logic [2:0] skew,
    input  logic       c_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic [1:0] err,
    output logic [7:0] count
);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_TMO  = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        RISE,
        FALL,
        DONE,
        ERR
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   c_s;
    logic [7:0]             target, target_n;
    logic [7:0]             count_n, count_inc;
    logic [7:0]             timer, timer_n;
    logic [1:0]             err_n;
    logic                   a_n, b_n;
    logic                   timed_out;

`ifdef MULLER_C_HS_SEQ_SKEW_EN
    localparam logic [1:0] ERR_EARLY = 2'b10;
    logic [2:0] skew_q, skew_n;
`else
    logic skew_unused;
    assign skew_unused = ^skew;
`endif

    assign c_s       = sync_q[SYNC_STAGES-1];
    assign count_inc = count + 8'd1;
    assign timed_out = (timer == TMO_LAST);
    assign busy      = (state == RISE) || (state == FALL);
    assign done      = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], c_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_out  <= 1'b0;
            b_out  <= 1'b0;
            err    <= ERR_NONE;
            count  <= '0;
            target <= '0;
            timer  <= '0;
`ifdef MULLER_C_HS_SEQ_SKEW_EN
            skew_q <= '0;
`endif
        end else begin
            state  <= state_n;
            a_out  <= a_n;
            b_out  <= b_n;
            err    <= err_n;
            count  <= count_n;
            target <= target_n;
            timer  <= timer_n;
`ifdef MULLER_C_HS_SEQ_SKEW_EN
            skew_q <= skew_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        count_n  = count;
        target_n = target;
        err_n    = err;
        timer_n  = timer + 8'd1;
`ifdef MULLER_C_HS_SEQ_SKEW_EN
        skew_n   = skew_q;
`endif
        unique case (state)
            IDLE: begin
                if (start && !c_s) begin
                    count_n  = '0;
                    target_n = n_cycles;
                    state_n  = (n_cycles == 8'd0) ? DONE : RISE;
                end
            end
            RISE: begin
`ifdef MULLER_C_HS_SEQ_SKEW_EN
                // b_out still lagging: hold the timer, any fire is premature
                if (!b_out) begin
                    timer_n = '0;
                    skew_n  = skew_q - 3'd1;
                    if (c_s) begin
                        state_n = ERR;
                        err_n   = ERR_EARLY;
                    end
                end else
`endif
                if (c_s) begin
                    state_n = FALL;
                end else if (timed_out) begin
                    state_n = ERR;
                    err_n   = ERR_TMO;
                end
            end
            FALL: begin
                if (!c_s) begin
                    count_n = count_inc;
                    state_n = (count_inc == target) ? DONE : RISE;
                end else if (timed_out) begin
                    state_n = ERR;
                    err_n   = ERR_TMO;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            ERR: begin
                if (clr) begin
                    state_n = IDLE;
                    err_n   = ERR_NONE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (state_n != state || !(state_n inside {RISE, FALL})) begin
            timer_n = '0;
        end

        a_n = (state_n == RISE);
        b_n = a_n;
`ifdef MULLER_C_HS_SEQ_SKEW_EN
        if (state_n == RISE) begin
            if (state != RISE) begin
                skew_n = skew;
                b_n    = (skew == 3'd0);
            end else begin
                b_n = b_out || (skew_q <= 3'd1);
            end
        end
`endif
    end
endmodule

// File: tb/tb_muller_c_hs_seq.sv
// tb_muller_c_hs_seq: randomized bursts against a C-element model with a
// cycle-level expectation of handshake timing, plus error and reset cases.
module tb_muller_c_hs_seq;
    localparam int SYNC = 2;
    localparam int TMO  = 10;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       start    = 1'b0;
    logic       clr      = 1'b0;
    logic [7:0] n_cycles = 8'd0;
    logic [2:0] skew     = 3'd0;
    logic       c_in;
    logic       a_out;
    logic       b_out;
    logic       busy;
    logic       done;
    logic [1:0] err;
    logic [7:0] count;

    int checks = 0;
    int errors = 0;

    // 0: C-element with dly-cycle output delay, 1: stuck 0, 2: stuck 1, 3: OR gate
    logic [1:0] cmode   = 2'd0;
    logic [2:0] dly     = 3'd0;
    logic       c_state = 1'b0;
    logic [5:0] dline   = '0;
    logic [6:0] taps;

    always #5 clk = ~clk;

    muller_c_hs_seq #(
        .SYNC_STAGES(SYNC),
        .TIMEOUT    (TMO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .clr     (clr),
        .n_cycles(n_cycles),
        .skew    (skew),
        .c_in    (c_in),
        .a_out   (a_out),
        .b_out   (b_out),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .count   (count)
    );

    always @(a_out or b_out) begin
        if (a_out === b_out) c_state = a_out;
    end

    always @(posedge clk) dline <= {dline[4:0], c_state};

    assign taps = {dline, c_state};

    always_comb begin
        case (cmode)
            2'd0:    c_in = taps[dly];
            2'd1:    c_in = 1'b0;
            2'd2:    c_in = 1'b1;
            default: c_in = a_out | b_out;
        endcase
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout, want finish");
        $fatal(1);
    end

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (a_out !== 1'b0 || b_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_ab: got a=%b b=%b, want 0 0", a_out, b_out);
        end
        checks++;
        if (count !== 8'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d, want 0", count);
        end
        repeat (8) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_done: got %b %b, want 0 0", busy, done);
        end
        checks++;
        if (err !== 2'b00) begin
            errors++;
            $display("FAIL reset_err: got %b, want 00", err);
        end
    endtask

    task automatic run_burst(input int n, input int d);
        int   exp_done;
        int   done_at;
        int   done_cnt;
        int   rises;
        int   ab_bad;
        int   err_bad;
        logic prev_a;
        cmode = 2'd0;
        dly   = 3'(d);
        skew  = 3'd0;
        repeat (8) @(negedge clk);
        n_cycles = 8'(n);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        exp_done = 2 * n * (SYNC + 1 + d);
        done_at  = -1;
        done_cnt = 0;
        rises    = 0;
        ab_bad   = 0;
        err_bad  = 0;
        prev_a   = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (a_out === 1'b1 && prev_a === 1'b0) rises++;
            prev_a = a_out;
            if (a_out !== b_out) ab_bad++;
            if (err !== 2'b00) err_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (done_at >= 0 && k >= done_at + 2) break;
            @(negedge clk);
        end
        checks++;
        if (done_at != exp_done) begin
            errors++;
            $display("FAIL burst_done_time n=%0d d=%0d: got %0d, want %0d",
                     n, d, done_at, exp_done);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL burst_done_width n=%0d: got %0d, want 1", n, done_cnt);
        end
        checks++;
        if (rises != n) begin
            errors++;
            $display("FAIL burst_rises n=%0d: got %0d, want %0d", n, rises, n);
        end
        checks++;
        if (count !== 8'(n)) begin
            errors++;
            $display("FAIL burst_count: got %0d, want %0d", count, n);
        end
        checks++;
        if (err_bad != 0) begin
            errors++;
            $display("FAIL burst_err n=%0d: got %0d cycles with err, want 0", n, err_bad);
        end
        checks++;
        if (ab_bad != 0) begin
            errors++;
            $display("FAIL burst_ab_sync n=%0d: got %0d split cycles, want 0", n, ab_bad);
        end
    endtask

    task automatic test_bursts();
        run_burst(3, 0);
        run_burst(0, 0);
        for (int i = 0; i < 8; i++) begin
            int n;
            int d;
            n = int'($urandom_range(1, 12));
            d = int'($urandom_range(0, 5));
            run_burst(n, d);
        end
    endtask

    task automatic test_timeout();
        cmode = 2'd1;
        repeat (6) @(negedge clk);
        n_cycles = 8'd1;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (err !== 2'b00 || a_out !== 1'b1) begin
            errors++;
            $display("FAIL tmo_wait: got err=%b a=%b, want 00 1", err, a_out);
        end
        @(negedge clk);
        checks++;
        if (err !== 2'b01) begin
            errors++;
            $display("FAIL tmo_err: got %b, want 01", err);
        end
        checks++;
        if (a_out !== 1'b0 || b_out !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_outputs: got a=%b b=%b busy=%b, want 0 0 0",
                     a_out, b_out, busy);
        end
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        checks++;
        if (err !== 2'b01 || a_out !== 1'b0) begin
            errors++;
            $display("FAIL tmo_sticky: got err=%b a=%b, want 01 0", err, a_out);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_clr: got err=%b busy=%b, want 00 0", err, busy);
        end
    endtask

    task automatic test_start_blocked();
        int bad;
        int found;
        cmode = 2'd2;
        repeat (4) @(negedge clk);
        n_cycles = 8'd1;
        start    = 1'b1;
        bad      = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy !== 1'b0 || a_out !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL blocked_idle: got %0d active cycles, want 0", bad);
        end
        cmode = 2'd0;
        dly   = 3'd0;
        repeat (SYNC) @(negedge clk);
        checks++;
        if (a_out !== 1'b0) begin
            errors++;
            $display("FAIL blocked_early: got a=%b, want 0", a_out);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (a_out !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL blocked_begin: got a=%b busy=%b, want 1 1", a_out, busy);
        end
        found = 0;
        for (int k = 0; k < 100; k++) begin
            if (done === 1'b1) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (found != 1 || count !== 8'd1) begin
            errors++;
            $display("FAIL blocked_done: got done=%0d count=%0d, want 1 1", found, count);
        end
    endtask

    task automatic test_reset_midburst();
        int found;
        cmode = 2'd0;
        dly   = 3'd0;
        repeat (8) @(negedge clk);
        n_cycles = 8'd4;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        found    = 0;
        for (int k = 0; k < 200; k++) begin
            if (busy === 1'b1 && a_out === 1'b0 && count === 8'd2) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (found != 1) begin
            errors++;
            $display("FAIL midrst_reach_fall: got %0d, want 1", found);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (a_out !== 1'b0 || b_out !== 1'b0 || count !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: got a=%b b=%b count=%0d busy=%b, want 0 0 0 0",
                     a_out, b_out, count, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || a_out !== 1'b0 || count !== 8'd0) begin
            errors++;
            $display("FAIL midrst_no_resume: got busy=%b a=%b count=%0d, want 0 0 0",
                     busy, a_out, count);
        end
        run_burst(1, 0);
    endtask

`ifdef MULLER_C_HS_SEQ_SKEW_EN
    task automatic test_skew();
        logic b_seen;
        cmode = 2'd3;
        skew  = 3'd4;
        repeat (6) @(negedge clk);
        n_cycles = 8'd1;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        b_seen   = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (b_out === 1'b1) b_seen = 1'b1;
            if (k == 0) begin
                checks++;
                if (a_out !== 1'b1 || b_out !== 1'b0) begin
                    errors++;
                    $display("FAIL skew_entry: got a=%b b=%b, want 1 0", a_out, b_out);
                end
            end
            if (k == 3) begin
                checks++;
                if (err !== 2'b10) begin
                    errors++;
                    $display("FAIL skew_early_fire: got %b, want 10", err);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (b_seen !== 1'b0) begin
            errors++;
            $display("FAIL skew_b_rose: got %b, want 0", b_seen);
        end
        clr = 1'b1;
        @(negedge clk);
        clr  = 1'b0;
        skew = 3'd0;
        @(negedge clk);
        checks++;
        if (err !== 2'b00) begin
            errors++;
            $display("FAIL skew_clr: got %b, want 00", err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_bursts();
        test_timeout();
        test_start_blocked();
        test_reset_midburst();
`ifdef MULLER_C_HS_SEQ_SKEW_EN
        test_skew();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
